// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the CNN activation/pooling datapath.
// Contents:
//   ACI_BW_DEF / B_BW_DEF / O_F_BW_DEF : default widths
//   relu_shift_sat()                   : ReLU, arithmetic right shift, unsigned saturation
package cnn_pkg;

  localparam int ACI_BW_DEF = 22;
  localparam int B_BW_DEF   = 16;
  localparam int O_F_BW_DEF = 8;

  // Negative sums clamp to zero; positive sums are shifted, then
  // saturated to the largest obw-bit unsigned value.
  function automatic logic [31:0] relu_shift_sat(input logic signed [63:0] sum,
                                                 input int unsigned       shift,
                                                 input int unsigned       obw);
    logic signed [63:0] sh;
    logic signed [63:0] lim;
    sh  = sum >>> shift;
    lim = (64'sd1 <<< obw) - 64'sd1;
    if (sum < 0) begin
      relu_shift_sat = '0;
    end else if (sh > lim) begin
      relu_shift_sat = lim[31:0];
    end else begin
      relu_shift_sat = sh[31:0];
    end
  endfunction

endpackage

// File: rtl/cnn_act_quant.sv
// Two-stage activation pipeline: bias add, then ReLU/shift/saturate.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   i_clear         : synchronous restart; drops both pipeline valid bits
//   i_bias          : signed per-channel bias
//   i_in_valid      : qualifies i_in_acc
//   i_in_acc        : signed conv accumulator value
//   o_act_valid     : activated sample valid (2 cycles after input)
//   o_act           : activated sample; holds its value between samples
module cnn_act_quant
  import cnn_pkg::*;
#(
  parameter int ACI_BW = ACI_BW_DEF,
  parameter int B_BW   = B_BW_DEF,
  parameter int O_F_BW = O_F_BW_DEF,
  parameter int SHIFT  = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic [B_BW-1:0]   i_bias,
  input  logic              i_in_valid,
  input  logic [ACI_BW-1:0] i_in_acc,
  output logic              o_act_valid,
  output logic [O_F_BW-1:0] o_act
);

  logic signed [ACI_BW:0] sum_q, sum_d;
  logic [O_F_BW-1:0]      act_q, act_d;
  logic                   v1_q, v2_q;

  always_comb begin
    sum_d = (ACI_BW+1)'($signed(i_in_acc)) + (ACI_BW+1)'($signed(i_bias));
    act_d = O_F_BW'(relu_shift_sat(64'(sum_q), SHIFT, O_F_BW));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
      act_q <= '0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
    end else if (i_clear) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= i_in_valid;
      v2_q <= v1_q;
      if (i_in_valid) sum_q <= sum_d;
      if (v1_q)       act_q <= act_d;
    end
  end

  assign o_act_valid = v2_q;
  assign o_act       = act_q;

endmodule

// File: rtl/cnn_relu_maxpool.sv
// Conv post-processing: bias + ReLU + shift/saturate, then optional 2x2 max pool.
// Build option: define CNN_MAXPOOL_EN to enable 2x2 pooling (row buffer of
// OW/2 entries, output latency 3). Without it every activated sample is
// output with latency 2.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   i_bias       : signed bias, static during a frame
//   i_clear      : synchronous frame restart (drops in-flight samples)
//   i_in_valid   : one conv pixel per asserted cycle, raster order
//   i_in_acc     : signed conv accumulator value
//   o_ot_valid   : single-cycle output strobe
//   o_ot_fmap    : activated (pooled) feature, holds when not valid
//   o_ot_last    : final output of the frame
module cnn_relu_maxpool
  import cnn_pkg::*;
#(
  parameter int ACI_BW = ACI_BW_DEF,
  parameter int B_BW   = B_BW_DEF,
  parameter int O_F_BW = O_F_BW_DEF,
  parameter int SHIFT  = 6,
  parameter int OW     = 24,
  parameter int OH     = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [B_BW-1:0]   i_bias,
  input  logic              i_clear,
  input  logic              i_in_valid,
  input  logic [ACI_BW-1:0] i_in_acc,
  output logic              o_ot_valid,
  output logic [O_F_BW-1:0] o_ot_fmap,
  output logic              o_ot_last
);

  localparam int CW = (OW > 1) ? $clog2(OW) : 1;
  localparam int RW = (OH > 1) ? $clog2(OH) : 1;

  logic              act_valid;
  logic [O_F_BW-1:0] act;

  cnn_act_quant #(
    .ACI_BW (ACI_BW),
    .B_BW   (B_BW),
    .O_F_BW (O_F_BW),
    .SHIFT  (SHIFT)
  ) u_act_quant (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clear     (i_clear),
    .i_bias      (i_bias),
    .i_in_valid  (i_in_valid),
    .i_in_acc    (i_in_acc),
    .o_act_valid (act_valid),
    .o_act       (act)
  );

  // Position of the activated sample currently presented on act.
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          at_last;

  assign at_last = (col_q == CW'(OW-1)) && (row_q == RW'(OH-1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (act_valid) begin
      if (col_q == CW'(OW-1)) begin
        col_d = '0;
        row_d = (row_q == RW'(OH-1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (i_clear) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

`ifdef CNN_MAXPOOL_EN
  localparam int HW = (OW/2 > 1) ? $clog2(OW/2) : 1;

  logic [O_F_BW-1:0] rowbuf_q [OW/2];
  logic [O_F_BW-1:0] hold_q;
  logic [O_F_BW-1:0] hmax, rb_rd, pool;
  logic [HW-1:0]     hidx;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [O_F_BW-1:0] out_fmap_q, out_fmap_d;

  // Even columns park the sample in hold_q; odd columns complete the
  // horizontal pair. Even rows stash the pair max, odd rows emit.
  always_comb begin
    hidx        = HW'(col_q >> 1);
    hmax        = (act > hold_q) ? act : hold_q;
    rb_rd       = rowbuf_q[hidx];
    pool        = (rb_rd > hmax) ? rb_rd : hmax;
    out_valid_d = act_valid & col_q[0] & row_q[0];
    out_last_d  = out_valid_d & at_last;
    out_fmap_d  = out_valid_d ? pool : out_fmap_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_fmap_q  <= '0;
    end else if (i_clear) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_fmap_q  <= out_fmap_d;
      if (act_valid && !col_q[0]) hold_q <= act;
    end
  end

  // Row buffer is always written before it is read within a frame, so it
  // carries no reset.
  always_ff @(posedge clk) begin
    if (act_valid && col_q[0] && !row_q[0] && !i_clear) begin
      rowbuf_q[hidx] <= hmax;
    end
  end

  assign o_ot_valid = out_valid_q;
  assign o_ot_last  = out_last_q;
  assign o_ot_fmap  = out_fmap_q;
`else
  assign o_ot_valid = act_valid;
  assign o_ot_last  = act_valid & at_last;
  assign o_ot_fmap  = act;
`endif

endmodule

// File: tb/tb_cnn_relu_maxpool.sv
module tb_cnn_relu_maxpool;

  localparam int ACI_BW = 22;
  localparam int B_BW   = 16;
  localparam int O_F_BW = 8;
  localparam int SHIFT  = 4;
  localparam int OW     = 4;
  localparam int OH     = 4;
`ifdef CNN_MAXPOOL_EN
  localparam bit POOL = 1'b1;
  localparam int LAT  = 3;
`else
  localparam bit POOL = 1'b0;
  localparam int LAT  = 2;
`endif
  localparam int FRAME_OUTS = POOL ? 4 : 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [B_BW-1:0]   i_bias;
  logic              i_clear;
  logic              i_in_valid;
  logic [ACI_BW-1:0] i_in_acc;
  logic              o_ot_valid;
  logic [O_F_BW-1:0] o_ot_fmap;
  logic              o_ot_last;

  cnn_relu_maxpool #(
    .ACI_BW (ACI_BW),
    .B_BW   (B_BW),
    .O_F_BW (O_F_BW),
    .SHIFT  (SHIFT),
    .OW     (OW),
    .OH     (OH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_bias     (i_bias),
    .i_clear    (i_clear),
    .i_in_valid (i_in_valid),
    .i_in_acc   (i_in_acc),
    .o_ot_valid (o_ot_valid),
    .o_ot_fmap  (o_ot_fmap),
    .o_ot_last  (o_ot_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int val;
    int last;
    int due;
  } exp_t;

  exp_t q[$];
  int   n_out = 0;
  int   held  = 0;

  // Output monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      held = 0;
    end else begin
      if (o_ot_valid) begin
        n_out++;
        check_eq("out_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check_eq("fmap", int'(o_ot_fmap), e.val);
          check_eq("last", int'(o_ot_last), e.last);
          check_eq("latency_cycle", cyc, e.due);
        end
        held = int'(o_ot_fmap);
      end else begin
        if (o_ot_last) check_eq("last_without_valid", 1, 0);
        if (int'(o_ot_fmap) != held) check_eq("fmap_hold", int'(o_ot_fmap), held);
      end
    end
  end

  // Hand-written frames: accumulator input and the activated value it yields.
  int cur_acc [16];
  int cur_act [16];

  task automatic load_ramp(input int offset);
    for (int i = 0; i < 16; i++) begin
      cur_acc[i] = (i << 4) + offset;
      cur_act[i] = i;
    end
  endtask

  task automatic load_mixed();
    cur_acc = '{10<<4, 200<<4, 90<<4, 40<<4,
                50<<4,  60<<4, 70<<4, 30<<4,
                -5,      7<<4, 'h100, 3<<4,
                100<<4,  8<<4, 'h00FFFF, 'h00FFFF};
    cur_act = '{10, 200, 90, 40,
                50,  60, 70, 30,
                 0,   7, 16,  3,
               100,   8, 255, 255};
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives samples 0..n-1 of the current frame; called at #1 after a posedge.
  task automatic run_samples(input int n, input int maxgap);
    exp_t e;
    int   r, c;
    for (int i = 0; i < n; i++) begin
      r = i / OW;
      c = i % OW;
      i_in_valid = 1'b1;
      i_in_acc   = ACI_BW'(cur_acc[i]);
      if (!POOL) begin
        e.val = cur_act[i];
        e.last = int'(i == OW*OH-1);
        e.due = cyc + LAT;
        q.push_back(e);
      end else if ((r % 2 == 1) && (c % 2 == 1)) begin
        e.val = max2(max2(cur_act[i-OW-1], cur_act[i-OW]), max2(cur_act[i-1], cur_act[i]));
        e.last = int'(i == OW*OH-1);
        e.due = cyc + LAT;
        q.push_back(e);
      end
      @(posedge clk);
      #1;
      i_in_valid = 1'b0;
      if (maxgap > 0) idle(int'($urandom_range(maxgap, 0)));
    end
  endtask

  task automatic run_frame(input string tag, input int maxgap);
    int n0;
    n0 = n_out;
    run_samples(OW*OH, maxgap);
    idle(LAT + 4);
    check_eq({tag, "_count"}, n_out - n0, FRAME_OUTS);
    check_eq({tag, "_drained"}, q.size(), 0);
  endtask

  initial begin
    exp_t keep[$];
    int   n0, mark;

    reset_n    = 1'b0;
    i_bias     = '0;
    i_clear    = 1'b0;
    i_in_valid = 1'b0;
    i_in_acc   = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", int'(o_ot_valid), 0);
    check_eq("rst_fmap", int'(o_ot_fmap), 0);
    check_eq("rst_last", int'(o_ot_last), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);

    // Ramp frame back-to-back, then with random gaps.
    load_ramp(0);
    run_frame("ramp", 0);
    run_frame("ramp_gaps", 5);

    // Mixed maxima positions, negative input, saturation and ties.
    load_mixed();
    run_frame("mixed", 0);

    // Negative bias cancelling a 0x100 offset on every sample.
    i_bias = B_BW'(-256);
    load_ramp('h100);
    run_frame("bias", 1);
    i_bias = '0;

    // Clear after a partial frame; the sample presented with i_clear is lost.
    load_ramp(0);
    n0 = n_out;
    run_samples(6, 0);
    i_clear    = 1'b1;
    i_in_valid = 1'b1;
    i_in_acc   = ACI_BW'(200 << 4);
    mark       = cyc;
    keep.delete();
    foreach (q[i]) if (q[i].due <= mark) keep.push_back(q[i]);
    q = keep;
    @(posedge clk);
    #1;
    i_clear    = 1'b0;
    i_in_valid = 1'b0;
    @(negedge clk);
    check_eq("valid_after_clear", int'(o_ot_valid), 0);
    idle(LAT + 4);
    check_eq("clear_partial_count", n_out - n0, POOL ? 0 : 5);
    run_frame("after_clear", 0);

    // Reset pulsed mid-frame while samples are still in flight.
    run_samples(5, 0);
    reset_n = 1'b0;
    mark    = cyc;
    keep.delete();
    foreach (q[i]) if (q[i].due < mark) keep.push_back(q[i]);
    q = keep;
    @(negedge clk);
    check_eq("midrst_valid", int'(o_ot_valid), 0);
    check_eq("midrst_fmap", int'(o_ot_fmap), 0);
    check_eq("midrst_last", int'(o_ot_last), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);
    check_eq("midrst_drained", q.size(), 0);
    run_frame("after_reset", 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
